id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Register-dependency scoreboard and issue controller for the decode stage. It tracks every in-flight register write issued past ID, holds the decoded instruction with `id_ready` while a source register is still pending, and releases it once the pending write has retired at writeback. It sits between `id_stage`, which supplies the rs/rd enables and addresses, and the pipeline issue point, which consumes `id_valid & id_ready`.

## Interface
- `CNT_W`, 2: width of each per-register pending counter. The maximum number of outstanding writes to one register is 2^CNT_W−1 = 3.
- `MAX_INFLIGHT`, 4: maximum number of tracked writes outstanding across all registers.
- `INF_W`, 3: width of `inflight`. Must hold `MAX_INFLIGHT`.

Ports:
- `clk` in 1: the only clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: a decoded instruction is presented.
- `rs1_r_ena` in 1, `rs1_r_addr` in 5: source 1 read request.
- `rs2_r_ena` in 1, `rs2_r_addr` in 5: source 2 read request.
- `rd_w_ena` in 1, `rd_w_addr` in 5: destination write request.
- `id_ready` out 1: issue grant. Combinational.
- `wb_valid` in 1, `wb_addr` in 5: one tracked write retires.
- `flush` in 1: discard all tracking state.
- `busy_mask` out 32: registered. Bit i = (cnt[i] != 0). Bit 0 is always 0.
- `inflight` out INF_W: registered count of tracked outstanding writes.
- `wb_err` out 1: registered, sticky. Signals that a retire was received for a non-pending register.

## Operation
- State: `cnt[1..31]` (CNT_W bits each), `inflight`, `wb_err`. Register x0 is never tracked.
- Hazard terms, all computed from registered state:
  - `raw = (rs1_r_ena & rs1_r_addr!=0 & cnt[rs1_r_addr]!=0) | (same terms for rs2)`.
  - `waw_sat = rd_w_ena & rd_w_addr!=0 & cnt[rd_w_addr]==2^CNT_W−1`.
  - `full = (inflight == MAX_INFLIGHT)`.
  - `full` and `waw_sat` block issue only when the instruction is tracked. An instruction with `rd_w_ena=0` or `rd_w_addr=0` is not blocked by them.
- `id_ready = ~rst & ~flush & ~raw & ~(trk & (waw_sat | full))`, where `trk = rd_w_ena & rd_w_addr!=0`.
- `id_ready` may be asserted while `id_valid=0`. It depends only on the current request fields and state.
- Issue: `fire = id_valid & id_ready`. When `fire & trk`: `cnt[rd_w_addr]+1` and `inflight+1`.
- Retire: `ret = wb_valid & wb_addr!=0 & cnt[wb_addr]!=0`. When `ret`: `cnt[wb_addr]−1` and `inflight−1`.
- `wb_valid` with `wb_addr=0` is ignored.
- `wb_valid` to a nonzero register with `cnt==0` changes no counter and sets `wb_err`.
- Issue and retire in the same cycle:
  - Same register: `cnt` unchanged and `inflight` unchanged.
  - Different registers: both counter updates apply and `inflight` is unchanged.
- No bypass: a retire does not clear a RAW hazard in its own cycle. The instruction issues at the earliest one cycle later.
- Flush: next state is all `cnt=0` and `inflight=0`. Any issue or retire in the flush cycle is discarded. `wb_err` is kept.
- Counters never wrap. Saturation is prevented by `waw_sat` and `full`, underflow by the `cnt!=0` guard.

## Timing
- Reset (`rst` high at a rising edge): all `cnt=0`, `inflight=0`, `busy_mask=0`, `wb_err=0`.
- While `rst` is high, `id_ready=0`.
- Reset mid-operation discards all pending state. Retires arriving afterwards for pre-reset issues set `wb_err`.
- `busy_mask`, `inflight` and `wb_err` update at the rising edge following the causing `fire`, `ret` or `flush`.
- Issue-to-busy latency is 1 cycle. A dependent instruction in the next cycle sees the hazard.
- Retire-to-ready latency is 1 cycle: `wb_valid` at cycle N gives `id_ready=1` at N+1, provided no other hazard is present.
- `flush` at cycle N gives `id_ready=0` at N and all-clear state at N+1.
- The `id_valid` handshake is ready/valid. The requester holds the fields stable until `fire`. The block takes no action on a dropped request.

## Test plan
- Reset then idle: `busy_mask=0`, `inflight=0`, `wb_err=0`, `id_ready=1` for any request after reset is released.
- RAW stall:
  - Issue with rd=x5 at cycle 1 gives `busy_mask[5]=1` at cycle 2.
  - A request with rs1=x5 sees `id_ready=0` until `wb_valid`, `wb_addr=5` at cycle 6.
  - `id_ready=1` at cycle 7, and `busy_mask[5]=0` at cycle 7.
- x0 and untracked cases:
  - rd=x0 issue: `inflight` stays 0.
  - rs1=x0 request: never stalls.
  - `wb_valid` with `wb_addr=0`: no `wb_err`.
- Limits:
  - Four tracked issues to x1..x4 give `inflight=4`. A fifth tracked request sees `id_ready=0`, while an rd=x0 request is ready.
  - Three issues to x7 give `cnt[7]=3`. A fourth write to x7 stalls.
- Simultaneous issue and retire:
  - Issue rd=x9 with a same-cycle retire of x9 (cnt 1): `cnt[9]` stays 1 and `inflight` is unchanged.
  - Retire of x10 with a same-cycle issue to x11: `busy_mask[10]=0` and `busy_mask[11]=1`.
- Flush and error:
  - Flush with 3 pending: `busy_mask=0` and `inflight=0` next cycle.
  - A subsequent `wb_valid`, `wb_addr=3` sets `wb_err=1`. `wb_err` stays 1 until `rst`.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// Decode-stage register scoreboard: counts in-flight writes per register and
// withholds id_ready while a source is pending or write tracking is exhausted.
module id_hazard_ctrl #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int INF_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             rs1_r_ena,
  input  logic [4:0]       rs1_r_addr,
  input  logic             rs2_r_ena,
  input  logic [4:0]       rs2_r_addr,
  input  logic             rd_w_ena,
  input  logic [4:0]       rd_w_addr,
  output logic             id_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  input  logic             flush,
  output logic [31:0]      busy_mask,
  output logic [INF_W-1:0] inflight,
  output logic             wb_err
);

  logic [CNT_W-1:0] cnt     [32];
  logic [CNT_W-1:0] cnt_nxt [32];
  logic [31:0]      busy_nxt;
  logic [INF_W-1:0] inflight_nxt;

  logic trk, raw, waw_sat, full, fire, inc, ret, err_set;

  always_comb begin
    trk     = rd_w_ena & (rd_w_addr != 5'd0);
    raw     = (rs1_r_ena & (rs1_r_addr != 5'd0) & (cnt[rs1_r_addr] != '0)) |
              (rs2_r_ena & (rs2_r_addr != 5'd0) & (cnt[rs2_r_addr] != '0));
    waw_sat = trk & (cnt[rd_w_addr] == '1);
    full    = (inflight == INF_W'(MAX_INFLIGHT));
    id_ready = ~rst & ~flush & ~raw & ~(trk & (waw_sat | full));
    fire    = id_valid & id_ready;
    inc     = fire & trk;
    ret     = wb_valid & (wb_addr != 5'd0) & (cnt[wb_addr] != '0);
    err_set = wb_valid & (wb_addr != 5'd0) & (cnt[wb_addr] == '0);
  end

  // Next-state: issue and retire applied in sequence so a same-register pair cancels.
  always_comb begin
    cnt_nxt      = cnt;
    inflight_nxt = inflight;
    if (flush) begin
      for (int i = 0; i < 32; i++) cnt_nxt[i] = '0;
      inflight_nxt = '0;
    end else begin
      if (inc) cnt_nxt[rd_w_addr] = cnt_nxt[rd_w_addr] + CNT_W'(1);
      if (ret) cnt_nxt[wb_addr]   = cnt_nxt[wb_addr] - CNT_W'(1);
      if (inc && !ret)      inflight_nxt = inflight + INF_W'(1);
      else if (ret && !inc) inflight_nxt = inflight - INF_W'(1);
    end
    busy_nxt = '0;
    for (int i = 1; i < 32; i++) busy_nxt[i] = (cnt_nxt[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
      inflight  <= '0;
      busy_mask <= '0;
      wb_err    <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      inflight  <= inflight_nxt;
      busy_mask <= busy_nxt;
      if (err_set) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed scenarios then random traffic, all
// checked against a per-register pending-count model.
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, rs1_r_ena, rs2_r_ena, rd_w_ena, wb_valid, flush;
  logic [4:0]  rs1_r_addr, rs2_r_addr, rd_w_addr, wb_addr;
  logic        id_ready, wb_err;
  logic [31:0] busy_mask;
  logic [2:0]  inflight;

  id_hazard_ctrl #(.CNT_W(2), .MAX_INFLIGHT(4), .INF_W(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
    .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr),
    .id_ready(id_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .flush(flush), .busy_mask(busy_mask), .inflight(inflight), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   pend [32];
  int   infl;
  bit   err;
  logic obs_ready;
  bit   last_fire;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(input logic en, input logic [4:0] a);
    return en && a != 0 && pend[a] != 0;
  endfunction

  function automatic logic model_ready();
    bit tracked = rd_w_ena && rd_w_addr != 0;
    if (rst || flush) return 1'b0;
    if (pending(rs1_r_ena, rs1_r_addr) || pending(rs2_r_ena, rs2_r_addr)) return 1'b0;
    if (tracked && (pend[rd_w_addr] == 3 || infl == 4)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m = '0;
    for (int i = 1; i < 32; i++) m[i] = (pend[i] != 0);
    return m;
  endfunction

  task automatic model_update(input logic rdy);
    bit fire = id_valid && rdy;
    bit wb_hit = wb_valid && wb_addr != 0 && pend[wb_addr] != 0;
    bit wb_bad = wb_valid && wb_addr != 0 && pend[wb_addr] == 0;
    last_fire = fire;
    if (rst) begin
      foreach (pend[i]) pend[i] = 0;
      infl = 0;
      err  = 0;
    end else if (flush) begin
      foreach (pend[i]) pend[i] = 0;
      infl = 0;
    end else begin
      if (wb_bad) err = 1;
      if (fire && rd_w_ena && rd_w_addr != 0) begin
        pend[rd_w_addr]++;
        infl++;
      end
      if (wb_hit) begin
        pend[wb_addr]--;
        infl--;
      end
    end
  endtask

  task automatic cycle();
    logic er;
    #1;
    er = model_ready();
    obs_ready = id_ready;
    chk("id_ready", id_ready, er);
    @(posedge clk);
    model_update(er);
    #1;
    chk("busy_mask", busy_mask, model_busy());
    chk("inflight", inflight, infl);
    chk("wb_err", wb_err, err);
  endtask

  task automatic drive(input logic v, input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2,
                       input logic we, input logic [4:0] wa,
                       input logic wv, input logic [4:0] wba, input logic fl);
    id_valid = v; rs1_r_ena = e1; rs1_r_addr = a1; rs2_r_ena = e2; rs2_r_addr = a2;
    rd_w_ena = we; rd_w_addr = wa; wb_valid = wv; wb_addr = wba; flush = fl;
  endtask

  task automatic issue(input logic [4:0] rd);
    drive(1, 0, 0, 0, 0, 1, rd, 0, 0, 0); cycle();
  endtask

  task automatic retire(input logic [4:0] a);
    drive(0, 0, 0, 0, 0, 0, 0, 1, a, 0); cycle();
  endtask

  initial begin
    foreach (pend[i]) pend[i] = 0;
    infl = 0; err = 0; last_fire = 0;

    rst = 1'b1;
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("rst_ready_low", obs_ready, 0);
    rst = 1'b0;
    drive(1, 1, 5, 1, 6, 0, 0, 0, 0, 0); cycle();
    chk("idle_ready", obs_ready, 1);
    chk("idle_busy", busy_mask, 0);
    chk("idle_inflight", inflight, 0);
    chk("idle_err", wb_err, 0);

    // RAW stall on x5 until its retire, released one cycle later.
    issue(5);
    chk("raw_busy5_set", busy_mask[5], 1);
    repeat (3) begin
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); cycle();
      chk("raw_stall", obs_ready, 0);
    end
    drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0); cycle();
    chk("raw_no_bypass", obs_ready, 0);
    chk("raw_busy5_clr", busy_mask[5], 0);
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("raw_release", obs_ready, 1);

    // x0 handling.
    issue(0);
    chk("x0_inflight", inflight, 0);
    issue(8);
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0); cycle();
    chk("x0_src_ready", obs_ready, 1);
    retire(0);
    chk("x0_wb_no_err", wb_err, 0);
    retire(8);

    // Global in-flight limit.
    for (int i = 1; i <= 4; i++) issue(5'(i));
    chk("full_inflight", inflight, 4);
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0); cycle();
    chk("full_stall", obs_ready, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); cycle();
    chk("full_untracked_ok", obs_ready, 1);
    for (int i = 1; i <= 4; i++) retire(5'(i));

    // Per-register saturation.
    repeat (3) issue(7);
    chk("sat_inflight", inflight, 3);
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); cycle();
    chk("sat_stall", obs_ready, 0);
    repeat (3) retire(7);
    chk("sat_drained", busy_mask[7], 0);

    // Simultaneous issue and retire.
    issue(9);
    drive(1, 0, 0, 0, 0, 1, 9, 1, 9, 0); cycle();
    chk("same_busy9", busy_mask[9], 1);
    chk("same_inflight", inflight, 1);
    retire(9);
    issue(10);
    drive(1, 0, 0, 0, 0, 1, 11, 1, 10, 0); cycle();
    chk("diff_busy10", busy_mask[10], 0);
    chk("diff_busy11", busy_mask[11], 1);
    retire(11);

    // Flush then stale retire sets sticky error, cleared only by reset.
    issue(1); issue(2); issue(3);
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 1); cycle();
    chk("flush_ready_low", obs_ready, 0);
    chk("flush_busy", busy_mask, 0);
    chk("flush_inflight", inflight, 0);
    retire(3);
    chk("stale_err", wb_err, 1);
    repeat (2) begin
      drive(1, 1, 3, 0, 0, 1, 3, 0, 0, 0); cycle();
      chk("err_sticky", wb_err, 1);
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    rst = 1'b0;
    chk("rst_err_clr", wb_err, 0);
    chk("rst_busy_clr", busy_mask, 0);

    // Random traffic with held requests until accepted.
    last_fire = 1;
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] w;
      if (last_fire || !id_valid) begin
        id_valid   = ($urandom_range(0, 3) != 0);
        rs1_r_ena  = $urandom_range(0, 1);
        rs1_r_addr = 5'($urandom_range(0, 7));
        rs2_r_ena  = $urandom_range(0, 1);
        rs2_r_addr = 5'($urandom_range(0, 7));
        rd_w_ena   = ($urandom_range(0, 3) != 0);
        rd_w_addr  = 5'($urandom_range(0, 7));
      end
      w = 5'($urandom_range(0, 7));
      for (int k = 0; k < 8 && pend[w] == 0; k++) w = 5'((w + 1) % 8);
      wb_addr  = ($urandom_range(0, 99) < 3) ? 5'($urandom_range(0, 31)) : w;
      wb_valid = ($urandom_range(0, 1) == 1);
      flush    = ($urandom_range(0, 99) < 2);
      if (flush) wb_valid = 1'b0;
      rst      = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
